// File: rtl/vram_slave.sv
// vram_slave: Wishbone-accessed 32-bit frame-buffer word store with a background fill engine.
//   clk_i, rst_ni      : clock, async active-low reset
//   clr_req, clr_val   : one-cycle fill request and the fill word
//   busy               : high while a fill sweep runs
//   cyc, stb, we, sel, adr, dat_i : Wishbone request from the master
//   dat_o, ack         : Wishbone read data and acknowledge
module vram_slave #(
    parameter int DEPTH = 19200,
    parameter int AW    = 15
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_req,
    input  logic [31:0] clr_val,
    output logic        busy,
    input  logic        cyc,
    input  logic        stb,
    input  logic        we,
    input  logic [3:0]  sel,
    input  logic [31:0] adr,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    output logic        ack
);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ACK, S_CLEAR} state_t;

    state_t        state;
    logic [AW-1:0] idx;
    logic [IW-1:0] ptr;
    logic          we_q;
    logic [3:0]    sel_q;
    logic [31:0]   wdat;
    logic [31:0]   fill;
    logic          pend;
    logic [31:0]   mem [DEPTH];

    logic          req;
    logic          last;
    logic          in_range;
    logic [IW-1:0] widx;
    logic          unused;

    assign req      = cyc & stb;
    assign last     = ptr == IW'(DEPTH - 1);
    assign in_range = {1'b0, idx} < (AW + 1)'(DEPTH);
    // Only used when in_range holds, so dropping the upper bits cannot alias.
    assign widx     = idx[IW-1:0];
    assign unused   = ^{adr[31:AW+2], adr[1:0]};
    // ack follows cyc live so a master that drops cyc in the ack cycle sees none.
    assign ack      = (state == S_ACK) && cyc;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= S_IDLE;
            dat_o <= '0;
            busy  <= 1'b0;
            pend  <= 1'b0;
            ptr   <= '0;
            idx   <= '0;
            we_q  <= 1'b0;
            sel_q <= '0;
            wdat  <= '0;
            fill  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        idx   <= adr[AW+1:2];
                        we_q  <= we;
                        sel_q <= sel;
                        wdat  <= dat_i;
                        state <= S_ACCESS;
                    end else if (clr_req) begin
                        fill  <= clr_val;
                        busy  <= 1'b1;
                        ptr   <= '0;
                        state <= S_CLEAR;
                    end
                end
                S_ACCESS: begin
                    if (cyc)
                        dat_o <= (!we_q && in_range) ? mem[widx] : '0;
                    state <= cyc ? S_ACK : S_IDLE;
                end
                S_ACK: state <= S_IDLE;
                S_CLEAR: begin
                    // Only the first request seen during the sweep is kept.
                    if (req && !pend) begin
                        idx   <= adr[AW+1:2];
                        we_q  <= we;
                        sel_q <= sel;
                        wdat  <= dat_i;
                        pend  <= 1'b1;
                    end
                    if (last) begin
                        busy  <= 1'b0;
                        pend  <= 1'b0;
                        state <= (pend || req) ? S_ACCESS : S_IDLE;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Storage has no reset; a reset mid-sweep leaves already-filled words in place.
    always_ff @(posedge clk_i) begin
        if (state == S_CLEAR)
            mem[ptr] <= fill;
        else if (state == S_ACCESS && cyc && we_q && in_range)
            for (int b = 0; b < 4; b++)
                if (sel_q[b])
                    mem[widx][8*b +: 8] <= wdat[8*b +: 8];
    end
endmodule

// File: doc/vram_slave.md
VRAM_SLAVE -- requirements
Module: vram_slave

Interface
REQ-001 Parameter DEPTH, default 19200, number of 32-bit words stored (320x240 8-bit pixels, 4 per word).
REQ-002 Parameter AW, default 15, word-address width; DEPTH <= 2**AW.
REQ-003 clk_i  in  1  system clock; sole clock of the block.
REQ-004 rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-005 clr_req  in  1  single-cycle pulse requesting a full memory fill.
REQ-006 clr_val  in  32  fill word, sampled in the cycle clr_req is high.
REQ-007 busy  out  1  high while a fill sweep is in progress.
REQ-008 bus  if_wb.slave  --  Wishbone responder port: cyc, stb, we, sel[3:0], adr[31:0] in; master write data (dat_i, dat_m under NO_MODPORT_EXPRESSIONS) 32 in; read data (dat_o, dat_s under NO_MODPORT_EXPRESSIONS) 32 out; ack out.

Function
REQ-009 Storage SHALL be a DEPTH x 32 word array; word index = adr[AW+1:2]; adr[1:0] ignored.
REQ-010 States SHALL be S_IDLE, S_ACCESS, S_ACK, S_CLEAR.
REQ-011 A request SHALL be accepted in cycle T when state is S_IDLE and cyc & stb; adr, we, sel, write data latched at end of T; state -> S_ACCESS.
REQ-012 In S_ACCESS (T+1), if cyc high: writes update only byte lanes with sel bit set; reads load dat_o from the addressed word; state -> S_ACK.
REQ-013 In S_ACK (T+2), ack SHALL equal cyc for exactly one cycle, dat_o holding the read word (0 for writes); state -> S_IDLE.
REQ-014 Latency SHALL be fixed: ack in cycle T+2 for every accepted request; back-to-back accept possible at T+3.
REQ-015 stb high in S_ACCESS or S_ACK SHALL be ignored (one outstanding request).
REQ-016 cyc low in S_ACCESS SHALL abort: no write, no ack, state -> S_IDLE; cyc low in S_ACK suppresses ack.
REQ-017 Word index >= DEPTH: reads return 32'h0, writes dropped, ack still given.
REQ-018 clr_req in S_IDLE with no stb: latch clr_val, busy=1, state -> S_CLEAR, sweep pointer = 0.
REQ-019 S_CLEAR SHALL write clr_val to one word per cycle, index 0..DEPTH-1; after index DEPTH-1, busy=0 next cycle, state -> S_IDLE.
REQ-020 clr_req while busy or in S_ACCESS/S_ACK SHALL be ignored.
REQ-021 clr_req and cyc & stb in the same S_IDLE cycle: bus request wins, clr_req dropped.
REQ-022 cyc & stb during S_CLEAR SHALL be latched as pending (no ack); after sweep completes, state -> S_ACCESS directly and request completes per REQ-012/013 if cyc still high, else discarded.
REQ-023 A pending request SHALL observe fill data (sweep completes first).
REQ-024 Outputs not otherwise driven: ack=0; dat_o holds last value.

Reset
REQ-025 rst_ni low SHALL immediately force state S_IDLE, ack=0, dat_o=32'h0, busy=0, pending cleared, sweep pointer 0.
REQ-026 Memory contents SHALL NOT be reset; a fill in progress is abandoned (words already written keep clr_val).
REQ-027 Deassertion of rst_ni is synchronous to clk_i by the integrator; first request accepted in first cycle after release.

Verification
REQ-028 Write adr=0x10, sel=4'hf, data=0xDEADBEEF; read adr=0x10 -> ack at T+2 of each, read dat_o=0xDEADBEEF.
REQ-029 Preload 0x11223344 at adr 0x20, write sel=4'b0101 data 0xAABBCCDD, read -> 0x11BB33DD.
REQ-030 clr_req with clr_val=0x55555555 -> busy high exactly DEPTH cycles; reads at word 0 and DEPTH-1 return 0x55555555.
REQ-031 Read issued 5 cycles into fill -> no ack until busy falls, then ack 2 cycles later with 0x55555555.
REQ-032 Read adr=4*DEPTH -> ack with 32'h0; write there leaves word 0 unchanged; cyc dropped at T+1 -> no ack, no write.
REQ-033 rst_ni low mid-fill and mid-read -> ack=0, busy=0, dat_o=0 asynchronously; subsequent write/read round-trip correct.
